// File: rtl/operand_fetch.sv
// Operand fetch stage: reads source registers with writeback bypass, tracks
// in-flight destinations in a busy scoreboard and hands operands to execute.

package rapid_pkg;
    localparam int XLEN = 32;
endpackage

module operand_fetch #(
    parameter int XLEN = rapid_pkg::XLEN
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_dec_valid,
    output logic            o_dec_ready,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic [4:0]      i_rd,
    input  logic            i_uses_rs1,
    input  logic            i_uses_rs2,
    input  logic            i_writes_rd,
    output logic [4:0]      o_rf_rs1,
    output logic [4:0]      o_rf_rs2,
    output logic            o_rf_rs1_out,
    output logic            o_rf_rs2_out,
    input  logic [XLEN-1:0] i_rf_rs1_data,
    input  logic [XLEN-1:0] i_rf_rs2_data,
    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [4:0]      o_ex_rd,
    output logic            o_ex_writes_rd,
    input  logic            i_flush,
    output logic [31:0]     o_busy_mask,
    output logic [15:0]     o_stall_count
);

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            ex_writes_rd_q, ex_writes_rd_d;
    logic [31:0]     busy_q, busy_d;
    logic [15:0]     stall_count_q, stall_count_d;

    logic wb_hit_rs1, wb_hit_rs2;
    logic hazard_rs1, hazard_rs2, hazard;
    logic issue;

    function automatic logic [XLEN-1:0] select_operand(
        input logic [4:0]      rs,
        input logic            wb_hit,
        input logic [XLEN-1:0] wb_data,
        input logic [XLEN-1:0] rf_data
    );
        if (rs == 5'd0) return '0;
        if (wb_hit)     return wb_data;
        return rf_data;
    endfunction

    assign o_rf_rs1     = i_rs1;
    assign o_rf_rs2     = i_rs2;
    assign o_rf_rs1_out = i_dec_valid & i_uses_rs1;
    assign o_rf_rs2_out = i_dec_valid & i_uses_rs2;

    // A same-cycle writeback of the source resolves the hazard via the bypass.
    assign wb_hit_rs1 = i_wb_valid && (i_wb_rd == i_rs1);
    assign wb_hit_rs2 = i_wb_valid && (i_wb_rd == i_rs2);
    assign hazard_rs1 = i_uses_rs1 && (i_rs1 != 5'd0) && busy_q[i_rs1] && !wb_hit_rs1;
    assign hazard_rs2 = i_uses_rs2 && (i_rs2 != 5'd0) && busy_q[i_rs2] && !wb_hit_rs2;
    assign hazard     = hazard_rs1 || hazard_rs2;

    assign o_dec_ready = !hazard && !i_flush && (!ex_valid_q || i_ex_ready);
    assign issue       = i_dec_valid && o_dec_ready;

    always_comb begin
        // NOTE: every _d takes its held value first, so no path can infer a latch.
        ex_valid_d     = ex_valid_q;
        ex_rs1_data_d  = ex_rs1_data_q;
        ex_rs2_data_d  = ex_rs2_data_q;
        ex_rd_d        = ex_rd_q;
        ex_writes_rd_d = ex_writes_rd_q;
        busy_d         = busy_q;
        stall_count_d  = stall_count_q;

        if (i_dec_valid && hazard && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end

        if (i_flush) begin
            ex_valid_d = 1'b0;
            busy_d     = '0;
        end else begin
            if (i_wb_valid) begin
                busy_d[i_wb_rd] = 1'b0;
            end
            // Applied after the clear so an issue to the same index stays busy.
            if (issue && i_writes_rd) begin
                busy_d[i_rd] = 1'b1;
            end
            if (issue) begin
                ex_valid_d     = 1'b1;
                ex_rs1_data_d  = select_operand(i_rs1, wb_hit_rs1, i_wb_data, i_rf_rs1_data);
                ex_rs2_data_d  = select_operand(i_rs2, wb_hit_rs2, i_wb_data, i_rf_rs2_data);
                ex_rd_d        = i_rd;
                ex_writes_rd_d = i_writes_rd;
            end else if (ex_valid_q && i_ex_ready) begin
                ex_valid_d = 1'b0;
            end
        end

        busy_d[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_data_q  <= '0;
            ex_rs2_data_q  <= '0;
            ex_rd_q        <= '0;
            ex_writes_rd_q <= 1'b0;
            busy_q         <= '0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs1_data_q  <= ex_rs1_data_d;
            ex_rs2_data_q  <= ex_rs2_data_d;
            ex_rd_q        <= ex_rd_d;
            ex_writes_rd_q <= ex_writes_rd_d;
            busy_q         <= busy_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign o_ex_valid     = ex_valid_q;
    assign o_ex_rs1_data  = ex_rs1_data_q;
    assign o_ex_rs2_data  = ex_rs2_data_q;
    assign o_ex_rd        = ex_rd_q;
    assign o_ex_writes_rd = ex_writes_rd_q;
    assign o_busy_mask    = busy_q;
    assign o_stall_count  = stall_count_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table, directed corner-case
// sequences and randomized traffic against a cycle-level behavioural model.

module tb_operand_fetch;

    localparam int XLEN = 32;

    typedef struct packed {
        logic        dec_valid;
        logic [4:0]  rs1;
        logic        uses_rs1;
        logic [4:0]  rs2;
        logic        uses_rs2;
        logic [4:0]  rd;
        logic        writes_rd;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic        wb_valid;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        ex_ready;
        logic        flush;
    } in_t;

    typedef struct packed {
        in_t         in;
        logic        exp_ready;
        logic        exp_ex_valid;
        logic [31:0] exp_op1;
        logic [31:0] exp_op2;
        logic [4:0]  exp_rd;
        logic        exp_wr;
        logic [31:0] exp_busy;
        logic [15:0] exp_stall;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic            dec_valid, dec_ready;
    logic [4:0]      rs1, rs2, rd;
    logic            uses_rs1, uses_rs2, writes_rd;
    logic [4:0]      rf_rs1, rf_rs2;
    logic            rf_rs1_out, rf_rs2_out;
    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid, ex_ready;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data;
    logic [4:0]      ex_rd;
    logic            ex_writes_rd;
    logic            flush;
    logic [31:0]     busy_mask;
    logic [15:0]     stall_count;

    operand_fetch #(.XLEN(XLEN)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_dec_valid    (dec_valid),
        .o_dec_ready    (dec_ready),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .i_rd           (rd),
        .i_uses_rs1     (uses_rs1),
        .i_uses_rs2     (uses_rs2),
        .i_writes_rd    (writes_rd),
        .o_rf_rs1       (rf_rs1),
        .o_rf_rs2       (rf_rs2),
        .o_rf_rs1_out   (rf_rs1_out),
        .o_rf_rs2_out   (rf_rs2_out),
        .i_rf_rs1_data  (rf_rs1_data),
        .i_rf_rs2_data  (rf_rs2_data),
        .i_wb_valid     (wb_valid),
        .i_wb_rd        (wb_rd),
        .i_wb_data      (wb_data),
        .o_ex_valid     (ex_valid),
        .i_ex_ready     (ex_ready),
        .o_ex_rs1_data  (ex_rs1_data),
        .o_ex_rs2_data  (ex_rs2_data),
        .o_ex_rd        (ex_rd),
        .o_ex_writes_rd (ex_writes_rd),
        .i_flush        (flush),
        .o_busy_mask    (busy_mask),
        .o_stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_busy [32];
    bit          m_valid;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_rd;
    bit          m_wr;
    int          m_stall;
    logic        last_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) m[i] = m_busy[i];
        return m;
    endfunction

    function automatic bit src_blocked(input logic used, input logic [4:0] rs);
        return used && (rs != 5'd0) && m_busy[rs] && !(wb_valid && (wb_rd == rs));
    endfunction

    function automatic logic [31:0] operand_of(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'h0;
        if (wb_valid && (wb_rd == rs)) return wb_data;
        return rf;
    endfunction

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_valid = 1'b0;
        m_op1   = '0;
        m_op2   = '0;
        m_rd    = '0;
        m_wr    = 1'b0;
        m_stall = 0;
    endtask

    function automatic in_t instr(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                                  input logic u2, input logic [4:0] d, input logic w,
                                  input logic [31:0] d1, input logic [31:0] d2);
        in_t s;
        s = '0;
        s.dec_valid = 1'b1;
        s.rs1 = s1; s.uses_rs1 = u1;
        s.rs2 = s2; s.uses_rs2 = u2;
        s.rd = d;   s.writes_rd = w;
        s.rf1 = d1; s.rf2 = d2;
        s.ex_ready = 1'b1;
        return s;
    endfunction

    task automatic drive(input in_t v);
        dec_valid   = v.dec_valid;
        rs1         = v.rs1;
        uses_rs1    = v.uses_rs1;
        rs2         = v.rs2;
        uses_rs2    = v.uses_rs2;
        rd          = v.rd;
        writes_rd   = v.writes_rd;
        rf_rs1_data = v.rf1;
        rf_rs2_data = v.rf2;
        wb_valid    = v.wb_valid;
        wb_rd       = v.wb_rd;
        wb_data     = v.wb_data;
        ex_ready    = v.ex_ready;
        flush       = v.flush;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick(input string tag);
        bit          h, rdy, iss;
        logic [31:0] op1, op2;
        #1;
        h   = src_blocked(uses_rs1, rs1) || src_blocked(uses_rs2, rs2);
        rdy = !h && !flush && (!m_valid || ex_ready);
        iss = dec_valid && rdy;
        op1 = operand_of(rs1, rf_rs1_data);
        op2 = operand_of(rs2, rf_rs2_data);
        last_ready = dec_ready;
        check({tag, ".dec_ready"}, 32'(dec_ready), 32'(rdy));
        check({tag, ".rf_ports"}, 32'({rf_rs1_out, rf_rs2_out, rf_rs1, rf_rs2}),
              32'({dec_valid & uses_rs1, dec_valid & uses_rs2, rs1, rs2}));
        @(posedge clk);
        if (dec_valid && h && m_stall < 65535) m_stall++;
        if (flush) begin
            m_valid = 1'b0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            if (wb_valid && wb_rd != 5'd0) m_busy[wb_rd] = 1'b0;
            if (iss && writes_rd && rd != 5'd0) m_busy[rd] = 1'b1;
            if (iss) begin
                m_valid = 1'b1;
                m_op1   = op1;
                m_op2   = op2;
                m_rd    = rd;
                m_wr    = writes_rd;
            end else if (m_valid && ex_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
        check({tag, ".busy"}, busy_mask, model_mask());
        check({tag, ".stall"}, 32'(stall_count), 32'(m_stall));
        if (m_valid) begin
            check({tag, ".op1"}, ex_rs1_data, m_op1);
            check({tag, ".op2"}, ex_rs2_data, m_op2);
            check({tag, ".rd_wr"}, 32'({ex_rd, ex_writes_rd}), 32'({m_rd, m_wr}));
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ex_valid"}, 32'(ex_valid), 32'h0);
        check({tag, ".ex_rs1"}, ex_rs1_data, 32'h0);
        check({tag, ".ex_rs2"}, ex_rs2_data, 32'h0);
        check({tag, ".ex_rd"}, 32'(ex_rd), 32'h0);
        check({tag, ".ex_wr"}, 32'(ex_writes_rd), 32'h0);
        check({tag, ".busy"}, busy_mask, 32'h0);
        check({tag, ".stall"}, 32'(stall_count), 32'h0);
    endtask

    // Asserts reset from wherever we are, checks the async clear, releases on a falling edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        drive('0);
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        in_t  s;

        s = instr(5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 32'hDEADBEEF, 32'h33);
        tbl[0] = '{in: s, exp_ready: 1'b1, exp_ex_valid: 1'b1, exp_op1: 32'h0, exp_op2: 32'h33,
                   exp_rd: 5'd0, exp_wr: 1'b0, exp_busy: 32'h0, exp_stall: 16'd0};
        s = instr(5'd2, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 32'h22, 32'h44);
        s.wb_valid = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'hAB;
        tbl[1] = '{in: s, exp_ready: 1'b1, exp_ex_valid: 1'b1, exp_op1: 32'h22, exp_op2: 32'hAB,
                   exp_rd: 5'd6, exp_wr: 1'b1, exp_busy: 32'h40, exp_stall: 16'd0};
        s = instr(5'd6, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 32'h66, 32'h0);
        tbl[2] = '{in: s, exp_ready: 1'b0, exp_ex_valid: 1'b0, exp_op1: 32'h0, exp_op2: 32'h0,
                   exp_rd: 5'd0, exp_wr: 1'b0, exp_busy: 32'h40, exp_stall: 16'd1};
        s.wb_valid = 1'b1; s.wb_rd = 5'd6; s.wb_data = 32'h600D;
        tbl[3] = '{in: s, exp_ready: 1'b1, exp_ex_valid: 1'b1, exp_op1: 32'h600D, exp_op2: 32'h0,
                   exp_rd: 5'd1, exp_wr: 1'b1, exp_busy: 32'h2, exp_stall: 16'd1};
        s = instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        s.dec_valid = 1'b0; s.wb_valid = 1'b1; s.wb_rd = 5'd0; s.wb_data = 32'hFFFF;
        tbl[4] = '{in: s, exp_ready: 1'b1, exp_ex_valid: 1'b0, exp_op1: 32'h0, exp_op2: 32'h0,
                   exp_rd: 5'd0, exp_wr: 1'b0, exp_busy: 32'h2, exp_stall: 16'd1};
        s = instr(5'd1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 32'h11, 32'h55);
        s.ex_ready = 1'b0;
        tbl[5] = '{in: s, exp_ready: 1'b1, exp_ex_valid: 1'b1, exp_op1: 32'h11, exp_op2: 32'h55,
                   exp_rd: 5'd7, exp_wr: 1'b1, exp_busy: 32'h82, exp_stall: 16'd1};

        drive('0);
        #2;
        do_reset("reset");

        for (int k = 0; k < 6; k++) begin
            string t;
            t = $sformatf("vec%0d", k);
            drive(tbl[k].in);
            tick(t);
            check({t, ".tbl_ready"}, 32'(last_ready), 32'(tbl[k].exp_ready));
            check({t, ".tbl_ex_valid"}, 32'(ex_valid), 32'(tbl[k].exp_ex_valid));
            check({t, ".tbl_busy"}, busy_mask, tbl[k].exp_busy);
            check({t, ".tbl_stall"}, 32'(stall_count), 32'(tbl[k].exp_stall));
            if (tbl[k].exp_ex_valid) begin
                check({t, ".tbl_op1"}, ex_rs1_data, tbl[k].exp_op1);
                check({t, ".tbl_op2"}, ex_rs2_data, tbl[k].exp_op2);
                check({t, ".tbl_rd_wr"}, 32'({ex_rd, ex_writes_rd}), 32'({tbl[k].exp_rd, tbl[k].exp_wr}));
            end
        end

        // RAW stall resolved by a same-cycle writeback
        do_reset("raw.reset");
        drive(instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h0, 32'h0));
        tick("raw.issue");
        check("raw.busy5_set", 32'(busy_mask[5]), 32'h1);
        s = instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 32'hBAD0BAD0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            drive(s);
            tick("raw.stall");
            check("raw.ready_low", 32'(last_ready), 32'h0);
            check("raw.stall_cnt", 32'(stall_count), 32'(c + 1));
        end
        s.wb_valid = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'h1234;
        drive(s);
        tick("raw.bypass");
        check("raw.accepted", 32'(last_ready), 32'h1);
        check("raw.op1", ex_rs1_data, 32'h1234);
        check("raw.busy5_clr", 32'(busy_mask[5]), 32'h0);
        check("raw.stall_hold", 32'(stall_count), 32'h3);

        // Backpressure holds the execute outputs
        drive(instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 32'hA1A1, 32'h0));
        tick("bp.first");
        s = instr(5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b0, 32'hB2B2, 32'h0);
        s.ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(s);
            tick("bp.hold");
            check("bp.ready_low", 32'(last_ready), 32'h0);
            check("bp.valid_held", 32'(ex_valid), 32'h1);
            check("bp.op1_held", ex_rs1_data, 32'hA1A1);
            check("bp.rd_held", 32'(ex_rd), 32'd10);
        end
        s.ex_ready = 1'b1;
        drive(s);
        tick("bp.release");
        check("bp.ready_high", 32'(last_ready), 32'h1);
        check("bp.op1_next", ex_rs1_data, 32'hB2B2);
        check("bp.rd_next", 32'(ex_rd), 32'd12);

        // Set beats clear on the same index
        s = instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h0, 32'h0);
        drive(s);
        tick("sc.first");
        s.wb_valid = 1'b1; s.wb_rd = 5'd7; s.wb_data = 32'h77;
        drive(s);
        tick("sc.both");
        check("sc.busy7_set", 32'(busy_mask[7]), 32'h1);
        s.dec_valid = 1'b0;
        drive(s);
        tick("sc.clear");
        check("sc.busy7_clr", 32'(busy_mask[7]), 32'h0);

        // Flush clears scoreboard and in-flight output
        do_reset("fl.reset");
        for (int r = 4; r < 8; r++) begin
            drive(instr(5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 32'h0, 32'h0));
            tick("fl.fill");
        end
        check("fl.busy_f0", busy_mask, 32'h000000F0);
        check("fl.valid_before", 32'(ex_valid), 32'h1);
        s = instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 32'h0, 32'h0);
        s.flush = 1'b1;
        drive(s);
        tick("fl.pulse");
        check("fl.no_accept", 32'(last_ready), 32'h0);
        check("fl.valid_after", 32'(ex_valid), 32'h0);
        check("fl.busy_after", busy_mask, 32'h0);

        // Reset in the middle of a stall
        drive(instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h0, 32'h0));
        tick("rs.issue");
        for (int c = 0; c < 2; c++) begin
            drive(instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 32'h0, 32'h0));
            tick("rs.stall");
        end
        check("rs.stall_before", 32'(stall_count), 32'h2);
        #2;
        do_reset("rs.midstall");
        drive(instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 32'h0, 32'h0));
        tick("rs.first_issue");
        check("rs.first_valid", 32'(ex_valid), 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            s.dec_valid = ($urandom_range(0, 3) != 0);
            s.rs1       = 5'($urandom_range(0, 7));
            s.uses_rs1  = 1'($urandom_range(0, 1));
            s.rs2       = 5'($urandom_range(0, 7));
            s.uses_rs2  = 1'($urandom_range(0, 1));
            s.rd        = 5'($urandom_range(0, 7));
            s.writes_rd = ($urandom_range(0, 3) != 0);
            s.rf1       = $urandom;
            s.rf2       = $urandom;
            s.wb_valid  = ($urandom_range(0, 2) == 0);
            s.wb_rd     = 5'($urandom_range(0, 7));
            s.wb_data   = $urandom;
            s.ex_ready  = ($urandom_range(0, 3) != 0);
            s.flush     = ($urandom_range(0, 40) == 0);
            drive(s);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
